// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
//
// MEM-stage data-memory sequencer. Takes a load or store from the EX/MEM
// register, issues it to a variable-latency memory over a req/gnt/rvalid
// handshake, and holds the pipeline (Stall_M) until the access finishes.
// Every access is bounded by a timeout. Cycles with Stall_M high are counted
// in a saturating counter.
//
// Ports
//   clk, rst_n        clock (rising edge), synchronous active-low reset
//   ALUResult_M       byte address of the access (low 2 bits dropped)
//   WriteData_M       store data
//   MemWrite_M        store in MEM stage
//   ResultSrc_M       2'b01 marks a load in MEM stage
//   Flush_M           squash the MEM-stage instruction
//   mem_req/we/addr/wdata   request side of the memory handshake
//   mem_gnt           memory accepted the request
//   mem_rvalid/rdata  response (load data or store acknowledge)
//   Stall_M           freeze PC, IF/ID, ID/EX, EX/MEM
//   ReadData_M        last completed load result
//   MemErr_M          one-cycle pulse when an access is aborted by timeout
//   StallCount        saturating count of stalled cycles
// -----------------------------------------------------------------------------
module dmem_access_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] ALUResult_M,
    input  logic [WIDTH-1:0] WriteData_M,
    input  logic             MemWrite_M,
    input  logic [1:0]       ResultSrc_M,
    input  logic             Flush_M,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             Stall_M,
    output logic [WIDTH-1:0] ReadData_M,
    output logic             MemErr_M,
    output logic [CNT_W-1:0] StallCount
);

    // Timeout counter is at least 8 bits wide and always wide enough
    // to hold TIMEOUT-1.
    localparam int TW = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_reg;
    state_t            state_next;

    logic [WIDTH-1:0]  addr_reg;
    logic [WIDTH-1:0]  wdata_reg;
    logic              we_reg;
    logic [TW-1:0]     tcnt_reg;
    logic              flushed_reg;
    logic              err_reg;
    logic [WIDTH-1:0]  rdata_reg;
    logic [CNT_W-1:0]  stall_cnt_reg;

    logic              access;
    logic              tmo;
    logic              resp;
    logic              abort;
    logic              in_flight;
    logic              squashed;

    // Only word-aligned addresses reach the memory.
    logic              unused_addr_lsbs;
    assign unused_addr_lsbs = ^ALUResult_M[1:0];

    assign access    = (MemWrite_M | (ResultSrc_M == 2'b01)) & ~Flush_M;
    assign tmo       = (tcnt_reg == T_LAST);
    assign in_flight = (state_reg == REQ) | (state_reg == WAIT);

    // A response only counts once the request has been granted; rvalid in
    // IDLE/DONE, or in REQ without gnt, is ignored.
    assign resp  = ((state_reg == REQ) & mem_gnt & mem_rvalid) |
                   ((state_reg == WAIT) & mem_rvalid);

    // A flush in REQ before gnt withdraws the request, so it outranks timeout.
    assign abort = ((state_reg == REQ) & ~(mem_gnt & mem_rvalid) &
                    ~(Flush_M & ~mem_gnt) & tmo) |
                   ((state_reg == WAIT) & ~mem_rvalid & tmo);

    // A load flushed after its request went out still completes on the bus
    // but must not disturb ReadData_M.
    assign squashed = flushed_reg | Flush_M;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (access) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (mem_gnt & mem_rvalid) begin
                    state_next = DONE;
                end else if (Flush_M & ~mem_gnt) begin
                    state_next = IDLE;
                end else if (tmo) begin
                    state_next = DONE;
                end else if (mem_gnt) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid | tmo) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // Stall_M is low here so the pipeline moves on; the inputs
                // still seen this cycle belong to the finished access.
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        Stall_M = 1'b0;
        mem_req = 1'b0;
        unique case (state_reg)
            IDLE:    Stall_M = access;
            REQ: begin
                Stall_M = 1'b1;
                mem_req = 1'b1;
            end
            WAIT:    Stall_M = 1'b1;
            DONE:    Stall_M = 1'b0;
            default: Stall_M = 1'b0;
        endcase
    end

    assign mem_we     = we_reg;
    assign mem_addr   = addr_reg;
    assign mem_wdata  = wdata_reg;
    assign ReadData_M = rdata_reg;
    assign MemErr_M   = err_reg;
    assign StallCount = stall_cnt_reg;

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_reg      <= '0;
            wdata_reg     <= '0;
            we_reg        <= 1'b0;
            tcnt_reg      <= '0;
            flushed_reg   <= 1'b0;
            err_reg       <= 1'b0;
            rdata_reg     <= '0;
            stall_cnt_reg <= '0;
        end else begin
            err_reg <= abort;

            if ((state_reg == IDLE) && access) begin
                addr_reg    <= {ALUResult_M[WIDTH-1:2], 2'b00};
                wdata_reg   <= WriteData_M;
                we_reg      <= MemWrite_M;
                tcnt_reg    <= '0;
                flushed_reg <= 1'b0;
            end else if (in_flight) begin
                tcnt_reg    <= tcnt_reg + 1'b1;
                flushed_reg <= flushed_reg | Flush_M;
            end

            if (!we_reg && !squashed) begin
                if (resp) begin
                    rdata_reg <= mem_rdata;
                end else if (abort) begin
                    rdata_reg <= '0;
                end
            end

            if (Stall_M && (stall_cnt_reg != {CNT_W{1'b1}})) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ALUResult_M;
    logic [31:0] WriteData_M;
    logic        MemWrite_M;
    logic [1:0]  ResultSrc_M;
    logic        Flush_M;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        Stall_M;
    logic [31:0] ReadData_M;
    logic        MemErr_M;
    logic [31:0] StallCount;

    int checks = 0;
    int errors = 0;

    // Reference state: last load result and total stalled cycles.
    logic [31:0] exp_rd;
    int          exp_sc;

    dmem_access_ctrl #(.WIDTH(32), .TIMEOUT(TO), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ALUResult_M(ALUResult_M), .WriteData_M(WriteData_M),
        .MemWrite_M(MemWrite_M), .ResultSrc_M(ResultSrc_M), .Flush_M(Flush_M),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .Stall_M(Stall_M), .ReadData_M(ReadData_M),
        .MemErr_M(MemErr_M), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete access. gd = REQ cycles without gnt before gnt (0 = gnt in
    // first REQ cycle); rd = cycles from gnt to rvalid (0 = same cycle).
    // fk = busy-cycle index at which Flush_M is asserted, -1 for none.
    // Ends in the cycle after the access (DONE, or IDLE after a withdrawn
    // request) with the access inputs still applied for DONE.
    task automatic do_access(input string name, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input int gd, input int rd, input int fk);
        int  n;
        int  last;
        bit  err;
        bit  withdrawn;
        n         = gd + rd;
        err       = (n > TO - 1);
        last      = err ? TO - 1 : n;
        withdrawn = (fk >= 0) && (fk < gd) && (fk <= last);
        if (withdrawn) begin
            last = fk;
            err  = 1'b0;
        end

        @(negedge clk);
        MemWrite_M  = we;
        ResultSrc_M = we ? 2'b00 : 2'b01;
        ALUResult_M = addr;
        WriteData_M = wdata;
        Flush_M     = 1'b0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        #1;
        chk({name, ".idle_stall"}, Stall_M, 1'b1);
        chk({name, ".idle_req"}, mem_req, 1'b0);
        exp_sc++;

        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            mem_gnt    = (k == gd);
            mem_rvalid = (k == n);
            mem_rdata  = (k == n) ? rdata : $urandom;
            Flush_M    = (k == fk);
            #1;
            chk({name, ".busy_stall"}, Stall_M, 1'b1);
            chk({name, ".req"}, mem_req, (k <= gd));
            if (k == 0) begin
                chk({name, ".addr"}, mem_addr, addr & 32'hFFFF_FFFC);
                chk({name, ".we"}, mem_we, we);
                chk({name, ".wdata"}, mem_wdata, wdata);
            end
            exp_sc++;
        end

        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        Flush_M    = 1'b0;
        if (withdrawn) begin
            MemWrite_M  = 1'b0;
            ResultSrc_M = 2'b00;
        end else if (!we && !(fk >= 0)) begin
            exp_rd = err ? 32'h0 : rdata;
        end
        #1;
        chk({name, ".end_stall"}, Stall_M, 1'b0);
        chk({name, ".end_req"}, mem_req, 1'b0);
        chk({name, ".err"}, MemErr_M, err);
        chk({name, ".rdata"}, ReadData_M, exp_rd);
        chk({name, ".stallcnt"}, StallCount, exp_sc);
        $display("access %-8s we=%0d addr=%h gd=%0d rd=%0d fk=%0d err=%0d rdata_out=%h stalls=%0d",
                 name, we, addr, gd, rd, fk, err, ReadData_M, StallCount);
    endtask

    task automatic idle_cycle(input string name);
        @(negedge clk);
        MemWrite_M  = 1'b0;
        ResultSrc_M = 2'b00;
        Flush_M     = 1'b0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        #1;
        chk({name, ".stall"}, Stall_M, 1'b0);
        chk({name, ".req"}, mem_req, 1'b0);
        chk({name, ".err"}, MemErr_M, 1'b0);
        chk({name, ".stallcnt"}, StallCount, exp_sc);
    endtask

    initial begin
        rst_n       = 1'b0;
        ALUResult_M = '0;
        WriteData_M = '0;
        MemWrite_M  = 1'b0;
        ResultSrc_M = 2'b00;
        Flush_M     = 1'b0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        exp_rd      = '0;
        exp_sc      = 0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst.req", mem_req, 1'b0);
        chk("rst.addr", mem_addr, 32'h0);
        chk("rst.rdata", ReadData_M, 32'h0);
        chk("rst.stallcnt", StallCount, 32'h0);
        rst_n = 1'b1;
        idle_cycle("rst_idle");

        // Load at 0x1003, gnt on 2nd REQ cycle, rvalid 3 cycles later.
        do_access("ld1003", 1'b0, 32'h0000_1003, 32'h0, 32'hDEAD_BEEF, 1, 3, -1);
        chk("ld1003.six_stalls", StallCount, 32'd6);
        idle_cycle("gap0");

        // Store with gnt and rvalid in the first REQ cycle.
        do_access("st20", 1'b1, 32'h0000_0020, 32'h1234_5678, 32'hAAAA_5555, 0, 0, -1);
        idle_cycle("gap1");

        // Memory grants but never responds; then never grants at all.
        do_access("tmo_w", 1'b0, 32'h0000_0100, 32'h0, 32'h0, 0, 40, -1);
        idle_cycle("gap2");
        do_access("tmo_r", 1'b0, 32'h0000_0104, 32'h0, 32'h0, 40, 0, -1);
        idle_cycle("gap3");

        // Back-to-back loads with single-cycle memory.
        do_access("ld40", 1'b0, 32'h0000_0040, 32'h0, 32'h1111_0040, 0, 0, -1);
        do_access("ld44", 1'b0, 32'h0000_0044, 32'h0, 32'h2222_0044, 0, 0, -1);
        idle_cycle("gap4");

        // Flush before gnt withdraws the request; flush in WAIT discards data.
        do_access("fl_req", 1'b0, 32'h0000_0200, 32'h0, 32'h3333_3333, 3, 0, 1);
        idle_cycle("gap5");
        do_access("fl_wait", 1'b0, 32'h0000_0204, 32'h0, 32'h4444_4444, 0, 3, 1);
        idle_cycle("gap6");

        // Randomized accesses, some long enough to time out.
        for (int i = 0; i < 24; i++) begin
            bit  we;
            int  gd;
            int  rd;
            int  fk;
            we = 1'($urandom_range(0, 1));
            gd = $urandom_range(0, 3);
            rd = $urandom_range(0, 6);
            fk = -1;
            if (($urandom_range(0, 5) == 0) && (rd > 0) && (gd + rd <= TO - 1)) begin
                fk = gd + 1;
            end
            do_access("rand", we, $urandom, $urandom, $urandom, gd, rd, fk);
            if ($urandom_range(0, 1) == 1) begin
                idle_cycle("rand_gap");
            end
        end
        idle_cycle("gap7");

        // Reset during WAIT, then a stray response.
        @(negedge clk);
        MemWrite_M  = 1'b0;
        ResultSrc_M = 2'b01;
        ALUResult_M = 32'h0000_0300;
        @(negedge clk);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt     = 1'b0;
        rst_n       = 1'b0;
        ResultSrc_M = 2'b00;
        @(negedge clk);
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
        exp_rd     = '0;
        exp_sc     = 0;
        #1;
        chk("mrst.req", mem_req, 1'b0);
        chk("mrst.we", mem_we, 1'b0);
        chk("mrst.addr", mem_addr, 32'h0);
        chk("mrst.wdata", mem_wdata, 32'h0);
        chk("mrst.stall", Stall_M, 1'b0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk("mrst.rdata", ReadData_M, exp_rd);
        chk("mrst.err", MemErr_M, 1'b0);
        chk("mrst.stallcnt", StallCount, exp_sc);
        $display("reset mid-access: rdata_out=%h stalls=%0d", ReadData_M, StallCount);
        idle_cycle("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
